encoder_volume_ctrl: RTL and testbench
======================================

// Module: encoder_volume_ctrl
// PURPOSE
//  Consumes the debounced rotary-encoder outputs (detent click, direction, switch level) and maintains a bounded control value plus a mute flag.
//  Publishes (value, mute) to the downstream register/codec writer through a valid/ready handshake.
//  Sits between the rotary encoder front end and the audio control register bank.
// PARAMETERS
//  VALUE_W       8        width of control value
//  VALUE_MAX     255      upper saturation limit (lower limit is 0); VALUE_MAX <= 2**VALUE_W-1
//  VALUE_INIT    128      value after reset
//  STEP          1        increment per detent (normal speed)
//  ACCEL_STEP    4        increment per detent when accelerated (ENC_ACCEL_EN only)
//  ACCEL_WINDOW  2000000  clk cycles; a detent within this many cycles of the previous same-direction detent is "fast"
// PORTS
//  clk           in   1        system clock
//  reset         in   1        synchronous, active-high reset
//  click         in   1        one-cycle strobe, one detent completed
//  clockwise     in   1        direction qualifier, sampled only when click=1 (1=increment)
//  enc_sw_value  in   1        debounced push-switch level (1=pressed)
//  upd_value     out  VALUE_W  current control value
//  upd_mute      out  1        current mute flag
//  upd_valid     out  1        (upd_value, upd_mute) changed and is not yet accepted
//  upd_ready     in   1        downstream accepts when upd_valid && upd_ready
// BEHAVIOUR
//  Reset: upd_value=VALUE_INIT, upd_mute=0, upd_valid=0, accel counter=0, last_dir=1, sw_dly=0, init_pending=1.
//  First cycle after reset deasserts: init_pending clears and upd_valid rises, so the initial value is published once.
//  Detent: on click, step = STEP (or ACCEL_STEP if fast). CW: value=min(value+step, VALUE_MAX). CCW: value=max(value-step, 0).
//   - Arithmetic in VALUE_W+1 bits, then clamp; never wraps. A detent at a limit leaves the value unchanged and raises no upd_valid.
//  Mute: a rising edge of enc_sw_value (sw_dly==0 && enc_sw_value==1) toggles upd_mute. Holding the switch has no further effect.
//  Latency: upd_value/upd_mute update on the clk edge after the click or switch edge; upd_valid is high in that same cycle.
//  A click and a switch edge in the same cycle are both applied; they produce one change event.
//  Handshake FSM (upd_state_t):
//   - UPD_IDLE: upd_valid=0. A change event moves to UPD_PENDING.
//   - UPD_PENDING: upd_valid=1; upd_value and upd_mute track the latest state (coalescing, not queued).
//     On valid&&ready with no change in the same cycle, go to UPD_IDLE.
//     On valid&&ready with a simultaneous change, stay in UPD_PENDING so the new data is offered next cycle.
//  upd_ready is ignored in UPD_IDLE. Reset mid-transfer drops the pending update and restarts from the reset values.
// CONFIGURATION
//  ENC_ACCEL_EN defined:
//   - Free-running saturating counter of cycles since the last click (saturates at ACCEL_WINDOW).
//   - A detent is fast when counter < ACCEL_WINDOW and clockwise==last_dir; fast detents step by ACCEL_STEP.
//   - The counter clears on every click. A direction reversal always uses STEP.
//  ENC_ACCEL_EN undefined: every detent steps by STEP; the counter and last_dir are not instantiated.
// STRUCTURE
//  Package encoder_ctrl_pkg: typedef enum logic {UPD_IDLE, UPD_PENDING} upd_state_t; localparam DIR_CW=1'b1, DIR_CCW=1'b0.
//  Sub-module detent_accel (clk, reset, click, clockwise -> fast): holds the window counter and last_dir.
//   - Instantiated only under ENC_ACCEL_EN; otherwise fast is tied to 0.
// TESTING
//  1. Release reset, hold upd_ready=0 -> upd_valid=1 from the first cycle after reset, upd_value=128, upd_mute=0; then set upd_ready=1 -> upd_valid=0 next cycle.
//  2. 3 CW clicks spaced > ACCEL_WINDOW apart, ready=1 -> upd_value 129,130,131; each accepted, one upd_valid per click.
//  3. Start at value 254, 3 slow CW clicks -> 255, then no change and no upd_valid; at value 1, 2 slow CCW clicks -> 0, then 0 with no upd_valid.
//  4. ready=0, 5 slow CW clicks from 128 -> upd_valid held high, upd_value=133; ready pulse -> single acceptance of 133, then IDLE.
//  5. Switch rises, held 100 cycles, falls, rises -> upd_mute 0->1->0, two change events; a click in the same cycle as a switch rise -> value+1 and mute toggled in one event.
//  6. ENC_ACCEL_EN defined, ACCEL_WINDOW=100: CW clicks 10 cycles apart from 128 -> 129,133,137; then a CCW click 10 cycles later -> 136. Macro undefined -> 129,130,131, then 130.

Source files
------------

// File: rtl/encoder_ctrl_pkg.sv
// Shared types and constants for the rotary-encoder volume control slice.
package encoder_ctrl_pkg;

  typedef enum logic {
    UPD_IDLE    = 1'b0,
    UPD_PENDING = 1'b1
  } upd_state_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/encoder_volume_ctrl_detent_accel.sv
// Detent acceleration detector: window counter since last click plus last direction.
// Only instantiated when ENC_ACCEL_EN is defined.
module detent_accel
  import encoder_ctrl_pkg::*;
#(
  parameter int ACCEL_WINDOW = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic click,
  input  logic clockwise,
  output logic fast
);

  localparam int CNT_W = $clog2(ACCEL_WINDOW + 1);
  localparam logic [CNT_W-1:0] WIN = CNT_W'(ACCEL_WINDOW);

  logic [CNT_W-1:0] cnt;
  logic             last_dir;

  // Counter saturates at the window so an idle encoder never looks "fast".
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      last_dir <= DIR_CW;
    end else if (click) begin
      cnt      <= '0;
      last_dir <= clockwise;
    end else if (cnt < WIN) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign fast = (cnt < WIN) && (clockwise == last_dir);

endmodule

// File: rtl/encoder_volume_ctrl.sv
// Bounded control value + mute flag driven by encoder detents, published over valid/ready.
// Optional detent acceleration is enabled by defining ENC_ACCEL_EN.
module encoder_volume_ctrl
  import encoder_ctrl_pkg::*;
#(
  parameter int VALUE_W      = 8,
  parameter int VALUE_MAX    = 255,
  parameter int VALUE_INIT   = 128,
  parameter int STEP         = 1,
  parameter int ACCEL_STEP   = 4,
  parameter int ACCEL_WINDOW = 2000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               click,
  input  logic               clockwise,
  input  logic               enc_sw_value,
  output logic [VALUE_W-1:0] upd_value,
  output logic               upd_mute,
  output logic               upd_valid,
  input  logic               upd_ready,
  output upd_state_t         dbg_state
);

  // Handshake: a transfer happens on any cycle with upd_valid && upd_ready.
  // upd_valid stays high until accepted; value/mute coalesce to the latest state.

  localparam int XW = VALUE_W + 1;
  localparam logic [XW-1:0]      MAX_X  = XW'(VALUE_MAX);
  localparam logic [VALUE_W-1:0] MAX_V  = VALUE_W'(VALUE_MAX);
  localparam logic [VALUE_W-1:0] INIT_V = VALUE_W'(VALUE_INIT);

  upd_state_t         state, state_nxt;
  logic               init_pending;
  logic               sw_dly;
  logic               fast;
  logic [XW-1:0]      step_x, sum_x, diff_x;
  logic [VALUE_W-1:0] value_nxt;
  logic               mute_nxt;
  logic               sw_rise;
  logic               change;

`ifdef ENC_ACCEL_EN
  detent_accel #(
    .ACCEL_WINDOW(ACCEL_WINDOW)
  ) u_detent_accel (
    .clk      (clk),
    .reset    (reset),
    .click    (click),
    .clockwise(clockwise),
    .fast     (fast)
  );
`else
  // Window has no meaning without acceleration; this term is constant 0.
  assign fast = (ACCEL_WINDOW < 0);
`endif

  always_comb begin
    step_x    = fast ? XW'(ACCEL_STEP) : XW'(STEP);
    sum_x     = {1'b0, upd_value} + step_x;
    diff_x    = {1'b0, upd_value} - step_x;
    value_nxt = upd_value;
    if (click) begin
      if (clockwise == DIR_CW)
        value_nxt = (sum_x > MAX_X) ? MAX_V : sum_x[VALUE_W-1:0];
      else
        value_nxt = diff_x[VALUE_W] ? '0 : diff_x[VALUE_W-1:0];
    end
    sw_rise  = enc_sw_value & ~sw_dly;
    mute_nxt = upd_mute ^ sw_rise;
    // A detent pinned at a limit leaves the value alone and is not an event.
    change   = init_pending | sw_rise | (value_nxt != upd_value);
  end

  always_comb begin
    state_nxt = state;
    upd_valid = 1'b0;
    case (state)
      UPD_IDLE: begin
        if (change) state_nxt = UPD_PENDING;
      end
      UPD_PENDING: begin
        upd_valid = 1'b1;
        if (upd_ready && !change) state_nxt = UPD_IDLE;
      end
      default: state_nxt = UPD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_value    <= INIT_V;
      upd_mute     <= 1'b0;
      sw_dly       <= 1'b0;
      init_pending <= 1'b1;
      state        <= UPD_IDLE;
    end else begin
      upd_value    <= value_nxt;
      upd_mute     <= mute_nxt;
      sw_dly       <= enc_sw_value;
      init_pending <= 1'b0;
      state        <= state_nxt;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_encoder_volume_ctrl.sv
// Self-checking bench for encoder_volume_ctrl: cycle table plus directed corner sequences.
module tb_encoder_volume_ctrl;
  import encoder_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       click = 1'b0;
  logic       clockwise = 1'b0;
  logic       enc_sw_value = 1'b0;
  logic       upd_ready = 1'b0;
  logic [7:0] upd_value;
  logic       upd_mute;
  logic       upd_valid;
  upd_state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         gap;
    logic       click;
    logic       cw;
    logic       sw;
    logic       ready;
    logic [7:0] value;
    logic       mute;
    logic       valid;
  } vec_t;

  vec_t vecs[22];

`ifdef ENC_ACCEL_EN
  localparam logic [7:0] EXP_ACC0 = 8'd129, EXP_ACC1 = 8'd133, EXP_ACC2 = 8'd137, EXP_ACC3 = 8'd136;
`else
  localparam logic [7:0] EXP_ACC0 = 8'd129, EXP_ACC1 = 8'd130, EXP_ACC2 = 8'd131, EXP_ACC3 = 8'd130;
`endif

  encoder_volume_ctrl #(
    .VALUE_W     (8),
    .VALUE_MAX   (255),
    .VALUE_INIT  (128),
    .STEP        (1),
    .ACCEL_STEP  (4),
    .ACCEL_WINDOW(100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .click       (click),
    .clockwise   (clockwise),
    .enc_sw_value(enc_sw_value),
    .upd_value   (upd_value),
    .upd_mute    (upd_mute),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] v, input logic m, input logic vld);
    check({name, ".value"}, 32'(upd_value), 32'(v));
    check({name, ".mute"},  32'(upd_mute),  32'(m));
    check({name, ".valid"}, 32'(upd_valid), 32'(vld));
    check({name, ".state"}, 32'(dbg_state), vld ? 32'(UPD_PENDING) : 32'(UPD_IDLE));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step_cycle(input logic c, input logic cw, input logic sw, input logic rdy);
    click        = c;
    clockwise    = cw;
    enc_sw_value = sw;
    upd_ready    = rdy;
    @(posedge clk);
    #1;
    click = 1'b0;
  endtask

  task automatic idle(input int n, input logic sw, input logic rdy);
    repeat (n) step_cycle(1'b0, 1'b0, sw, rdy);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_out(name, 8'd128, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic reset_and_accept(input string name);
    do_reset(name);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_out({name, ".init_accepted"}, 8'd128, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 8'd128, 1'b0, 1'b1};
    vecs[1]  = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 8'd128, 1'b0, 1'b1};
    vecs[2]  = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 8'd128, 1'b0, 1'b0};
    vecs[3]  = '{110, 1'b1, 1'b1, 1'b0, 1'b1, 8'd129, 1'b0, 1'b1};
    vecs[4]  = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 8'd129, 1'b0, 1'b0};
    vecs[5]  = '{110, 1'b1, 1'b1, 1'b0, 1'b1, 8'd130, 1'b0, 1'b1};
    vecs[6]  = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 8'd130, 1'b0, 1'b0};
    vecs[7]  = '{110, 1'b1, 1'b1, 1'b0, 1'b1, 8'd131, 1'b0, 1'b1};
    vecs[8]  = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 8'd131, 1'b0, 1'b0};
    vecs[9]  = '{0,   1'b0, 1'b0, 1'b1, 1'b1, 8'd131, 1'b1, 1'b1};
    vecs[10] = '{0,   1'b0, 1'b0, 1'b1, 1'b1, 8'd131, 1'b1, 1'b0};
    vecs[11] = '{100, 1'b0, 1'b0, 1'b1, 1'b1, 8'd131, 1'b1, 1'b0};
    vecs[12] = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 8'd131, 1'b1, 1'b0};
    vecs[13] = '{0,   1'b0, 1'b0, 1'b1, 1'b1, 8'd131, 1'b0, 1'b1};
    vecs[14] = '{0,   1'b0, 1'b0, 1'b1, 1'b1, 8'd131, 1'b0, 1'b0};
    vecs[15] = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 8'd131, 1'b0, 1'b0};
    vecs[16] = '{110, 1'b1, 1'b1, 1'b1, 1'b1, 8'd132, 1'b1, 1'b1};
    vecs[17] = '{0,   1'b0, 1'b0, 1'b1, 1'b1, 8'd132, 1'b1, 1'b0};
    vecs[18] = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 8'd132, 1'b1, 1'b0};
    vecs[19] = '{110, 1'b1, 1'b1, 1'b0, 1'b0, 8'd133, 1'b1, 1'b1};
    vecs[20] = '{0,   1'b0, 1'b0, 1'b1, 1'b1, 8'd133, 1'b0, 1'b1};
    vecs[21] = '{0,   1'b0, 1'b0, 1'b1, 1'b1, 8'd133, 1'b0, 1'b0};

    // Table: init publish, slow CW clicks, mute toggling, click+switch in one event.
    do_reset("reset");
    for (int i = 0; i < 22; i++) begin
      idle(vecs[i].gap, (i > 0) ? vecs[i-1].sw : 1'b0, vecs[i].ready);
      step_cycle(vecs[i].click, vecs[i].cw, vecs[i].sw, vecs[i].ready);
      check_out($sformatf("vec%0d", i), vecs[i].value, vecs[i].mute, vecs[i].valid);
    end

    // Coalescing while downstream stalls, then a single acceptance.
    reset_and_accept("coal");
    for (int i = 0; i < 5; i++) begin
      idle(110, 1'b0, 1'b0);
      step_cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check_out($sformatf("coal.click%0d", i), 8'(129 + i), 1'b0, 1'b1);
    end
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_out("coal.accept", 8'd133, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_out("coal.after", 8'd133, 1'b0, 1'b0);

    // Reset while an update is pending drops it and republishes the initial value.
    idle(110, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check_out("midrst.pending", 8'd134, 1'b0, 1'b1);
    reset = 1'b1;
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_out("midrst.reset", 8'd128, 1'b0, 1'b0);
    reset = 1'b0;
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_out("midrst.republish", 8'd128, 1'b0, 1'b1);

    // Upper saturation.
    reset_and_accept("sat_hi");
    for (int i = 0; i < 126; i++) begin
      idle(110, 1'b0, 1'b1);
      step_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    end
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_out("sat_hi.254", 8'd254, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(110, 1'b0, 1'b1);
      step_cycle(1'b1, 1'b1, 1'b0, 1'b1);
      check_out($sformatf("sat_hi.click%0d", i), 8'd255, 1'b0, (i == 0));
    end

    // Lower saturation.
    reset_and_accept("sat_lo");
    for (int i = 0; i < 127; i++) begin
      idle(110, 1'b0, 1'b1);
      step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    end
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_out("sat_lo.1", 8'd1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      idle(110, 1'b0, 1'b1);
      step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
      check_out($sformatf("sat_lo.click%0d", i), 8'd0, 1'b0, (i == 0));
    end

    // Rapid clicks 10 cycles apart, then a direction reversal.
    reset_and_accept("accel");
    idle(110, 1'b0, 1'b1);
    step_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check_out("accel.c0", EXP_ACC0, 1'b0, 1'b1);
    idle(9, 1'b0, 1'b1);
    step_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check_out("accel.c1", EXP_ACC1, 1'b0, 1'b1);
    idle(9, 1'b0, 1'b1);
    step_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check_out("accel.c2", EXP_ACC2, 1'b0, 1'b1);
    idle(9, 1'b0, 1'b1);
    step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_out("accel.ccw", EXP_ACC3, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
